// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID        = 8;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned div;
    div = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head byte, count, full and empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             pop_ok_c;
  logic             push_ok_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [PTR_W-1:0] rd_nxt_c;
  logic [WIDTH-1:0] head_nxt_c;

  // A push while full is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    pop_ok_c    = pop && (count != CNT_W'(0));
    push_ok_c   = push && ((count != CNT_W'(DEPTH)) || pop_ok_c);
    count_nxt_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    rd_nxt_c    = rd_ptr + PTR_W'(pop_ok_c);
    head_nxt_c  = data;
    if (push_ok_c && ((count == CNT_W'(0)) || (pop_ok_c && (count == CNT_W'(1))))) begin
      head_nxt_c = push_data;
    end else if (pop_ok_c) begin
      head_nxt_c = mem[rd_nxt_c];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_ok_c);
      rd_ptr <= rd_nxt_c;
      count  <= count_nxt_c;
      data   <= head_nxt_c;
      empty  <= (count_nxt_c == CNT_W'(0));
      full   <= (count_nxt_c == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a
// show-ahead receive FIFO with sticky framing and overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 80_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        iCLK,
  input  logic                        iRESETn,
  input  logic                        iRX,
  output logic [7:0]                  oDATA,
  input  logic                        iREAD,
  output logic                        oEMPTY,
  output logic                        oFULL,
  output logic [$clog2(FIFO_DEPTH):0] oCOUNT,
  output logic                        oFRAME_ERR,
  output logic                        oOVERRUN,
  input  logic                        iCLR_ERR
);

  localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  state_t           state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       sample_cnt;
  logic             s7;
  logic             s8;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic tick_c;
  logic decide_c;
  logic vote_c;
  logic fall_c;
  logic push_c;
  logic pop_c;
  logic frame_set_c;
  logic overrun_set_c;

  // Decision uses the two stored samples plus the live sample 9.
  always_comb begin
    tick_c        = (state != ST_IDLE) && (div_cnt == DIV_W'(DIV - 1));
    decide_c      = tick_c && (sample_cnt == 4'(MID + 1));
    vote_c        = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
    fall_c        = rx_prev & ~rx_sync;
    push_c        = (state == ST_STOP) && decide_c && vote_c;
    frame_set_c   = (state == ST_STOP) && decide_c && !vote_c;
    pop_c         = iREAD && !oEMPTY;
    overrun_set_c = push_c && oFULL && !pop_c;
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= iRX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Tick and sample counters sit at zero in IDLE so sampling phase follows the start edge.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      sample_cnt <= '0;
      s7         <= 1'b1;
      s8         <= 1'b1;
      bit_idx    <= '0;
      shift      <= '0;
    end else begin
      if (state == ST_IDLE || tick_c) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state == ST_IDLE) begin
        sample_cnt <= '0;
      end else if (tick_c) begin
        sample_cnt <= sample_cnt + 4'd1;
        if (sample_cnt == 4'(MID - 1)) s7 <= rx_sync;
        if (sample_cnt == 4'(MID))     s8 <= rx_sync;
      end

      // Sample counter free-runs across bits, so each state's next decision is one bit later.
      case (state)
        ST_IDLE: begin
          bit_idx <= '0;
          if (fall_c) state <= ST_START;
        end
        ST_START: begin
          if (decide_c) state <= vote_c ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (decide_c) begin
            shift <= {vote_c, shift[7:1]};
            if (bit_idx == 3'd7) state <= ST_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (decide_c) state <= vote_c ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      oFRAME_ERR <= 1'b0;
      oOVERRUN   <= 1'b0;
    end else begin
      oFRAME_ERR <= frame_set_c | (oFRAME_ERR & ~iCLR_ERR);
      oOVERRUN   <= overrun_set_c | (oOVERRUN & ~iCLR_ERR);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (iCLK),
    .rst_n     (iRESETn),
    .push      (push_c),
    .push_data (shift),
    .pop       (iREAD),
    .data      (oDATA),
    .empty     (oEMPTY),
    .full      (oFULL),
    .count     (oCOUNT)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 1.6 MHz / 10 kbaud (10 clk per tick, 160 clk per bit).
module tb_uart_rx_fifo;

  localparam int BIT = 160;

  logic       iCLK;
  logic       iRESETn;
  logic       iRX;
  logic [7:0] oDATA;
  logic       iREAD;
  logic       oEMPTY;
  logic       oFULL;
  logic [4:0] oCOUNT;
  logic       oFRAME_ERR;
  logic       oOVERRUN;
  logic       iCLR_ERR;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .FIFO_DEPTH (16)
  ) dut (
    .iCLK       (iCLK),
    .iRESETn    (iRESETn),
    .iRX        (iRX),
    .oDATA      (oDATA),
    .iREAD      (iREAD),
    .oEMPTY     (oEMPTY),
    .oFULL      (oFULL),
    .oCOUNT     (oCOUNT),
    .oFRAME_ERR (oFRAME_ERR),
    .oOVERRUN   (oOVERRUN),
    .iCLR_ERR   (iCLR_ERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  // Drivers keep the phase at 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    iRX = v;
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop, n);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic pop_one();
    iREAD = 1'b1;
    @(posedge iCLK);
    #1;
    iREAD = 1'b0;
  endtask

  task automatic pulse_clr();
    iCLR_ERR = 1'b1;
    @(posedge iCLK);
    #1;
    iCLR_ERR = 1'b0;
  endtask

  task automatic test_reset();
    iRESETn = 1'b0; iRX = 1'b1; iREAD = 1'b0; iCLR_ERR = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    checks++; if (oDATA !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", oDATA); end
    checks++; if (oEMPTY !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", oEMPTY); end
    checks++; if (oFULL !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", oFULL); end
    checks++; if (oCOUNT !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", oCOUNT); end
    checks++; if ({oFRAME_ERR, oOVERRUN} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {oFRAME_ERR, oOVERRUN}); end
    iRESETn = 1'b1;
    idle(20);
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1, BIT);
      begin
        // Stop-bit decision tick lands on edge 1542 -> 1543; FIFO shows the byte after edge 1543.
        repeat (1542) @(posedge iCLK);
        @(negedge iCLK);
        checks++; if (oEMPTY !== 1'b1) begin errors++; $display("FAIL a5_empty_pre: got %b want 1", oEMPTY); end
        @(posedge iCLK);
        @(negedge iCLK);
        checks++; if (oEMPTY !== 1'b0) begin errors++; $display("FAIL a5_empty_post: got %b want 0", oEMPTY); end
        checks++; if (oDATA !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", oDATA); end
        checks++; if (oCOUNT !== 5'd1) begin errors++; $display("FAIL a5_count: got %0d want 1", oCOUNT); end
      end
    join
    idle(50);
    pop_one();
    checks++; if (oEMPTY !== 1'b1) begin errors++; $display("FAIL a5_pop_empty: got %b want 1", oEMPTY); end
    checks++; if (oCOUNT !== 5'd0) begin errors++; $display("FAIL a5_pop_count: got %0d want 0", oCOUNT); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp = '{8'h00, 8'hFF, 8'h55};
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, BIT);
    idle(100);
    checks++; if (oCOUNT !== 5'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", oCOUNT); end
    checks++; if ({oFRAME_ERR, oOVERRUN} !== 2'b00) begin errors++; $display("FAIL b2b_flags: got %b want 00", {oFRAME_ERR, oOVERRUN}); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (oDATA !== exp[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, oDATA, exp[i]); end
      pop_one();
    end
    checks++; if (oEMPTY !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", oEMPTY); end
  endtask

  task automatic test_glitch();
    drive_bit(1'b0, 40);
    idle(300);
    checks++; if (oEMPTY !== 1'b1) begin errors++; $display("FAIL glitch_empty: got %b want 1", oEMPTY); end
    checks++; if (oCOUNT !== 5'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", oCOUNT); end
    checks++; if ({oFRAME_ERR, oOVERRUN} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b want 00", {oFRAME_ERR, oOVERRUN}); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, BIT);
    drive_bit(1'b0, 500);
    checks++; if (oFRAME_ERR !== 1'b1) begin errors++; $display("FAIL fe_set: got %b want 1", oFRAME_ERR); end
    checks++; if (oEMPTY !== 1'b1) begin errors++; $display("FAIL fe_discard: got empty=%b want 1", oEMPTY); end
    // Clearing mid-break must stick: a held-low line may not raise a second error.
    pulse_clr();
    drive_bit(1'b0, 1500);
    checks++; if (oFRAME_ERR !== 1'b0) begin errors++; $display("FAIL fe_break_once: got %b want 0", oFRAME_ERR); end
    idle(100);
    checks++; if (oCOUNT !== 5'd0) begin errors++; $display("FAIL fe_count: got %0d want 0", oCOUNT); end
    send_frame(8'h3C, 1'b1, BIT);
    idle(50);
    checks++; if (oCOUNT !== 5'd1) begin errors++; $display("FAIL fe_good_count: got %0d want 1", oCOUNT); end
    checks++; if (oDATA !== 8'h3C) begin errors++; $display("FAIL fe_good_data: got %h want 3c", oDATA); end
    checks++; if (oFRAME_ERR !== 1'b0) begin errors++; $display("FAIL fe_good_flag: got %b want 0", oFRAME_ERR); end
    pop_one();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, BIT);
    idle(50);
    checks++; if (oFULL !== 1'b1) begin errors++; $display("FAIL ovr_fill_full: got %b want 1", oFULL); end
    checks++; if (oCOUNT !== 5'd16) begin errors++; $display("FAIL ovr_fill_count: got %0d want 16", oCOUNT); end
    checks++; if (oOVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_fill_flag: got %b want 0", oOVERRUN); end
    // Clear pulse coincides with the dropped push; the set must win.
    fork
      send_frame(8'h10, 1'b1, BIT);
      begin
        repeat (1542) @(posedge iCLK);
        #1 iCLR_ERR = 1'b1;
        @(posedge iCLK);
        #1 iCLR_ERR = 1'b0;
      end
    join
    idle(50);
    checks++; if (oOVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", oOVERRUN); end
    checks++; if (oCOUNT !== 5'd16) begin errors++; $display("FAIL ovr_count: got %0d want 16", oCOUNT); end
    checks++; if (oDATA !== 8'h00) begin errors++; $display("FAIL ovr_head: got %h want 00", oDATA); end
    pulse_clr();
    checks++; if (oOVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", oOVERRUN); end
    // FIFO still holds 0x00..0x0F; read on the push cycle of 0x10.
    fork
      send_frame(8'h10, 1'b1, BIT);
      begin
        repeat (1542) @(posedge iCLK);
        #1 iREAD = 1'b1;
        @(posedge iCLK);
        #1 iREAD = 1'b0;
      end
    join
    idle(50);
    checks++; if (oOVERRUN !== 1'b0) begin errors++; $display("FAIL pp_flag: got %b want 0", oOVERRUN); end
    checks++; if (oCOUNT !== 5'd16) begin errors++; $display("FAIL pp_count: got %0d want 16", oCOUNT); end
    checks++; if (oFULL !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", oFULL); end
    for (int i = 1; i <= 16; i++) begin
      checks++; if (oDATA !== 8'(i)) begin errors++; $display("FAIL pp_data%0d: got %h want %h", i, oDATA, 8'(i)); end
      pop_one();
    end
    checks++; if ({oEMPTY, oFULL} !== 2'b10) begin errors++; $display("FAIL pp_drained: got empty,full=%b want 10", {oEMPTY, oFULL}); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h7E;
    send_frame(8'h42, 1'b1, BIT);
    send_frame(8'h00, 1'b0, BIT);
    drive_bit(1'b0, 100);
    idle(100);
    checks++; if ({oCOUNT, oFRAME_ERR} !== {5'd1, 1'b1}) begin errors++; $display("FAIL rm_pre: got count=%0d ferr=%b want 1,1", oCOUNT, oFRAME_ERR); end
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 3; i++) drive_bit(b[i], BIT);
    drive_bit(b[3], 80);
    iRESETn = 1'b0;
    #1;
    checks++; if (oDATA !== 8'h00) begin errors++; $display("FAIL rm_data: got %h want 00", oDATA); end
    checks++; if ({oEMPTY, oFULL} !== 2'b10) begin errors++; $display("FAIL rm_empty_full: got %b want 10", {oEMPTY, oFULL}); end
    checks++; if (oCOUNT !== 5'd0) begin errors++; $display("FAIL rm_count: got %0d want 0", oCOUNT); end
    checks++; if ({oFRAME_ERR, oOVERRUN} !== 2'b00) begin errors++; $display("FAIL rm_flags: got %b want 00", {oFRAME_ERR, oOVERRUN}); end
    iRX = 1'b1;
    repeat (5) @(posedge iCLK);
    #1;
    iRESETn = 1'b1;
    idle(100);
    send_frame(8'h81, 1'b1, BIT);
    idle(50);
    checks++; if (oCOUNT !== 5'd1) begin errors++; $display("FAIL rm_next_count: got %0d want 1", oCOUNT); end
    checks++; if (oDATA !== 8'h81) begin errors++; $display("FAIL rm_next_data: got %h want 81", oDATA); end
    pop_one();
  endtask

  task automatic test_baud_tol();
    logic [7:0] exp [4];
    int         bt  [4];
    exp = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};
    bt  = '{155, 155, 165, 165};
    for (int i = 0; i < 4; i++) begin
      send_frame(exp[i], 1'b1, bt[i]);
      idle(30);
    end
    checks++; if (oCOUNT !== 5'd4) begin errors++; $display("FAIL baud_count: got %0d want 4", oCOUNT); end
    checks++; if ({oFRAME_ERR, oOVERRUN} !== 2'b00) begin errors++; $display("FAIL baud_flags: got %b want 00", {oFRAME_ERR, oOVERRUN}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (oDATA !== exp[i]) begin errors++; $display("FAIL baud_data%0d: got %h want %h", i, oDATA, exp[i]); end
      pop_one();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_baud_tol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
